// File: rtl/mmio_io_pkg.sv
// Shared definitions for the MMIO peripheral: register indices, segment type
// and the hex-to-seven-segment lookup.
package mmio_io_pkg;

  localparam logic [2:0] IDX_SW        = 3'd0;
  localparam logic [2:0] IDX_LED       = 3'd1;
  localparam logic [2:0] IDX_SEG_DATA  = 3'd2;
  localparam logic [2:0] IDX_SEG_BLANK = 3'd3;
  localparam logic [2:0] IDX_SW_EDGE   = 3'd4;

  typedef logic [7:0] seg_t;

  // Segment order {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
  function automatic seg_t hex7(input logic [3:0] v);
    seg_t s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mmio_seg_scan.sv
// Multiplexed seven-segment scanner: dwell counter, current digit index and
// registered segment/enable outputs.
module mmio_seg_scan
  import mmio_io_pkg::*;
#(
  parameter int unsigned NDIG      = 8,
  parameter int unsigned SCAN_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*NDIG-1:0]     seg_data,
  input  logic [NDIG-1:0]       seg_blank,
  output logic [7:0]            seg,
  output logic [NDIG-1:0]       dig_en
);

  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [SCAN_LOG2-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDXW-1:0]      dig_idx_q, dig_idx_d;
  seg_t                 seg_q, seg_d;
  logic [NDIG-1:0]      dig_en_q, dig_en_d;

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == '1) begin
      if (dig_idx_q == IDXW'(NDIG - 1))
        dig_idx_d = '0;
      else
        dig_idx_d = dig_idx_q + 1'b1;
    end

    // Segments and enable are registered from the same digit index so the
    // pattern and the active digit always change on the same edge.
    seg_d    = 8'hFF;
    dig_en_d = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (dig_idx_q == IDXW'(i) && !seg_blank[i]) begin
        dig_en_d[i] = 1'b0;
        seg_d       = hex7(seg_data[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
      seg_q      <= 8'hFF;
      dig_en_q   <= '1;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      seg_q      <= seg_d;
      dig_en_q   <= dig_en_d;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O block: address decode, LED/display registers, debounced
// switch input with sticky change flags, and the display scanner.
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int unsigned N         = 64,
  parameter logic [N-1:0] BASE_ADDR = 'h8000,
  parameter int unsigned SW_W      = 16,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned NDIG      = 8,
  parameter int unsigned DEB_LOG2  = 16,
  parameter int unsigned SCAN_LOG2 = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      addr,
  input  logic [N-1:0]      writeData,
  input  logic              memWrite,
  input  logic              memRead,
  output logic [N-1:0]      readData,
  output logic              io_hit,
  input  logic [SW_W-1:0]   i_sw,
  output logic [LED_W-1:0]  o_led,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   dig_en
);

  logic       in_win;
  logic [2:0] idx;
  logic       wr_en;

  logic [LED_W-1:0]    led_q, led_d;
  logic [4*NDIG-1:0]   seg_data_q, seg_data_d;
  logic [NDIG-1:0]     seg_blank_q, seg_blank_d;
  logic [SW_W-1:0]     sw_edge_q, sw_edge_d;
  logic [SW_W-1:0]     sync1_q, sync1_d;
  logic [SW_W-1:0]     sw_s_q, sw_s_d;
  logic [SW_W-1:0]     samp_q, samp_d;
  logic [SW_W-1:0]     deb_q, deb_d;
  logic [DEB_LOG2-1:0] deb_cnt_q, deb_cnt_d;
  logic                tick;
  logic [SW_W-1:0]     clr_mask;

  logic unused_bits;
  assign unused_bits = ^{addr[2:0], writeData};

  assign in_win = (addr[N-1:6] == BASE_ADDR[N-1:6]);
  assign idx    = addr[5:3];
  assign wr_en  = memWrite & in_win;
  assign io_hit = in_win & (memRead | memWrite);
  assign tick   = (deb_cnt_q == '0);

  always_comb begin
    led_d       = led_q;
    seg_data_d  = seg_data_q;
    seg_blank_d = seg_blank_q;
    clr_mask    = '0;
    if (wr_en) begin
      case (idx)
        IDX_LED:       led_d       = writeData[LED_W-1:0];
        IDX_SEG_DATA:  seg_data_d  = writeData[4*NDIG-1:0];
        IDX_SEG_BLANK: seg_blank_d = writeData[NDIG-1:0];
        IDX_SW_EDGE:   clr_mask    = writeData[SW_W-1:0];
        default:       ;
      endcase
    end

    sync1_d   = i_sw;
    sw_s_d    = sync1_q;
    deb_cnt_d = deb_cnt_q + 1'b1;
    samp_d    = samp_q;
    deb_d     = deb_q;
    // A bit is accepted only if it matched the previous tick's sample.
    if (tick) begin
      samp_d = sw_s_q;
      for (int unsigned i = 0; i < SW_W; i++) begin
        if (sw_s_q[i] == samp_q[i])
          deb_d[i] = sw_s_q[i];
      end
    end

    // Set has priority over a same-cycle write-1-to-clear.
    sw_edge_d = (sw_edge_q & ~clr_mask) | (deb_d ^ deb_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q       <= '0;
      seg_data_q  <= '0;
      seg_blank_q <= '1;
      sw_edge_q   <= '0;
      sync1_q     <= '0;
      sw_s_q      <= '0;
      samp_q      <= '0;
      deb_q       <= '0;
      deb_cnt_q   <= '0;
    end else begin
      led_q       <= led_d;
      seg_data_q  <= seg_data_d;
      seg_blank_q <= seg_blank_d;
      sw_edge_q   <= sw_edge_d;
      sync1_q     <= sync1_d;
      sw_s_q      <= sw_s_d;
      samp_q      <= samp_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
    end
  end

  always_comb begin
    readData = '0;
    if (in_win) begin
      case (idx)
        IDX_SW:        readData[SW_W-1:0]   = deb_q;
        IDX_LED:       readData[LED_W-1:0]  = led_q;
        IDX_SEG_DATA:  readData[4*NDIG-1:0] = seg_data_q;
        IDX_SEG_BLANK: readData[NDIG-1:0]   = seg_blank_q;
        IDX_SW_EDGE:   readData[SW_W-1:0]   = sw_edge_q;
        default:       readData = '0;
      endcase
    end
  end

  assign o_led = led_q;

  mmio_seg_scan #(
    .NDIG      (NDIG),
    .SCAN_LOG2 (SCAN_LOG2)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .seg_data  (seg_data_q),
    .seg_blank (seg_blank_q),
    .seg       (seg),
    .dig_en    (dig_en)
  );

endmodule
